strassen_tile_loader: RTL and testbench
=======================================

# strassen_tile_loader

Upstream operand stage for the 2x2 Strassen multiplier `matmult1`. It accepts a serial valid/ready stream of eight signed elements, assembles them into one A/B tile pair, and drives them stable onto the multiplier's `a11..b22` inputs. It then waits a fixed multiplier latency, captures `c11..c22`, and presents the result tile with a valid/ready handshake. One tile is in flight at a time.

## Interface
- `DATA_W`, 32: element and result width; all elements are signed two's complement.
- `MULT_LAT`, 3: cycles from the operands becoming stable to the `matmult1` outputs being valid. Legal range is 1..15.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_data` holds an element.
- `in_ready` out 1: the loader can accept an element.
- `in_data` in DATA_W: element, sent in order a11, a12, a21, a22, b11, b12, b21, b22.
- `mm_a11..mm_a22` out DATA_W each: A operands to `matmult1`.
- `mm_b11..mm_b22` out DATA_W each: B operands to `matmult1`.
- `mm_c11..mm_c22` in DATA_W each: results from `matmult1`.
- `out_valid` out 1: the result tile is valid.
- `out_ready` in 1: the consumer accepts the result tile.
- `out_c11..out_c22` out DATA_W each: captured results.
- `tile_count` out 16: completed tiles. Present only when `STRASSEN_LOADER_PERF_EN` is defined.

## Operation
- FSM states are IDLE, LOAD, WAIT and OUT.
- **IDLE**
  - `in_ready`=1.
  - An accepted element (`in_valid && in_ready`) is written to slot 0, the index becomes 1, and the FSM moves to LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each accepted element is written to slot[index] and the index increments.
  - When slot 7 is accepted, the FSM moves to WAIT and the wait counter is loaded with MULT_LAT.
  - Gaps (`in_valid`=0) stall the load without penalty.
- **WAIT**
  - `in_ready`=0.
  - The counter decrements every cycle.
  - When the counter reaches 1, the next edge captures `mm_c*` into `out_c*` and the FSM moves to OUT.
- **OUT**
  - `out_valid`=1 and `in_ready`=0.
  - `out_c*` are held until `out_valid && out_ready`; that edge returns the FSM to IDLE.
- **Operand registers**
  - `mm_*` are driven directly from the slot registers.
  - They change only when their slot is written, so they stay stable through WAIT and OUT.
- **Arithmetic**
  - There is no arithmetic in the loader.
  - Results are captured bit-exact, with no widening or saturation; overflow is owned by `matmult1`.
- **Reset**
  - While `rst_n`=0: FSM=IDLE, index=0, counter=0, all `mm_*` and `out_c*` = 0, `out_valid`=0, `in_ready`=0.
  - `in_ready` rises on the first cycle after `rst_n` returns high.
  - Reset mid-LOAD, mid-WAIT or mid-OUT discards the partial or pending tile, with no output pulse.
- **Boundary conditions**
  - `in_valid` asserted during WAIT/OUT is ignored, and the element is not consumed.
  - `out_ready` asserted outside OUT has no effect.
  - `out_ready` held high permanently gives one-cycle OUT occupancy.

## Timing
- The 8th element is accepted at edge k:
  - `mm_b22` is updated at edge k.
  - `out_c*` are captured and `out_valid` rises at edge k+MULT_LAT.
- Minimum tile period is 8 + MULT_LAT + 1 cycles, given back-to-back input and `out_ready` always high.
- `in_ready` rises on the edge where the OUT handshake completes.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- With `STRASSEN_LOADER_PERF_EN` defined:
  - A 16-bit `tile_count` port exists.
  - It resets to 0.
  - It increments on each OUT handshake.
  - It saturates at 16'hFFFF.
- Without the macro, the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `strassen_pkg`:
  - `loader_state_t` enum (IDLE/LOAD/WAIT/OUT).
  - Slot index constants `SLOT_A11`=0 … `SLOT_B22`=7.
  - `NUM_SLOTS`=8.
  - Default `DATA_W`.
- One sub-module, `strassen_slot_bank`:
  - Eight DATA_W registers.
  - Write enable plus 3-bit index.
  - Synchronous active-low clear.
  - Exposes all slots in parallel.
- The FSM, wait counter and output capture live in the top module.

## Test plan
1. **Basic tile.** Stream 0,1,2,3,4,5,6,7 with `matmult1` attached and `out_ready`=1. Expected:
   - `out_c11..out_c22` = 6, 7, 26, 31.
   - `out_valid` rises exactly MULT_LAT edges after the 8th accept.
2. **Gapped input and backpressure.** Same data with `in_valid` toggling 1/0, and `out_ready`=0 for 5 cycles in OUT. Expected:
   - Same results.
   - `out_c*` are stable and `in_ready`=0 throughout the stall.
   - `in_ready`=1 the cycle after the handshake.
3. **Negative operands.** Stream -1, 2, 3, -4, 5, -6, -7, 8. Expected: `out_c*` = -19, 22, 43, -50.
4. **Ignored input.** `in_valid`=1 with data 99 held throughout WAIT/OUT. Expected:
   - No slot changes.
   - 99 is accepted only as a11 of the next tile once back in IDLE.
5. **Reset mid-operation.** Drop `rst_n` for 1 cycle after 5 elements are accepted, then stream 0..7. Expected:
   - All outputs are 0 during reset.
   - No spurious `out_valid`.
   - The next result is 6, 7, 26, 31.
6. **Tile counter** (with `STRASSEN_LOADER_PERF_EN`). Run 3 tiles, then reset. Expected: `tile_count` = 1, 2, 3 after each handshake, and 0 after reset.

Source files
------------

// File: rtl/strassen_pkg.sv
// Shared types and constants for the Strassen 2x2 operand loader.
package strassen_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam int unsigned NUM_SLOTS      = 8;
   localparam int unsigned SLOT_IDX_W     = 3;
   localparam int unsigned CNT_W          = 4;

   localparam logic [SLOT_IDX_W-1:0] SLOT_A11 = 3'd0;
   localparam logic [SLOT_IDX_W-1:0] SLOT_A12 = 3'd1;
   localparam logic [SLOT_IDX_W-1:0] SLOT_A21 = 3'd2;
   localparam logic [SLOT_IDX_W-1:0] SLOT_A22 = 3'd3;
   localparam logic [SLOT_IDX_W-1:0] SLOT_B11 = 3'd4;
   localparam logic [SLOT_IDX_W-1:0] SLOT_B12 = 3'd5;
   localparam logic [SLOT_IDX_W-1:0] SLOT_B21 = 3'd6;
   localparam logic [SLOT_IDX_W-1:0] SLOT_B22 = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      OUT
   } loader_state_t;

endpackage

// File: rtl/strassen_slot_bank.sv
// Eight operand registers written one at a time, read all in parallel.
module strassen_slot_bank
   import strassen_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic                                clk,
   input  logic                                clr_n,
   input  logic                                we,
   input  logic [SLOT_IDX_W-1:0]               idx,
   input  logic [DATA_W-1:0]                   wdata,
   output logic [NUM_SLOTS-1:0][DATA_W-1:0]    slots
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         slots <= '0;
      end else if (we) begin
         slots[idx] <= wdata;
      end
   end

endmodule

// File: rtl/strassen_tile_loader.sv
// Serial-to-tile operand loader and result capture for the matmult1 2x2 multiplier.
// Optional STRASSEN_LOADER_PERF_EN adds a saturating completed-tile counter.
module strassen_tile_loader
   import strassen_pkg::*;
#(
   parameter int unsigned DATA_W   = DEFAULT_DATA_W,
   parameter int unsigned MULT_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] mm_a11,
   output logic [DATA_W-1:0] mm_a12,
   output logic [DATA_W-1:0] mm_a21,
   output logic [DATA_W-1:0] mm_a22,
   output logic [DATA_W-1:0] mm_b11,
   output logic [DATA_W-1:0] mm_b12,
   output logic [DATA_W-1:0] mm_b21,
   output logic [DATA_W-1:0] mm_b22,
   input  logic [DATA_W-1:0] mm_c11,
   input  logic [DATA_W-1:0] mm_c12,
   input  logic [DATA_W-1:0] mm_c21,
   input  logic [DATA_W-1:0] mm_c22,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_c11,
   output logic [DATA_W-1:0] out_c12,
   output logic [DATA_W-1:0] out_c21,
   output logic [DATA_W-1:0] out_c22
`ifdef STRASSEN_LOADER_PERF_EN
   ,
   output logic [15:0]       tile_count
`endif
);

   loader_state_t                        state;
   logic [SLOT_IDX_W-1:0]                idx;
   logic [CNT_W-1:0]                     cnt;
   logic [NUM_SLOTS-1:0][DATA_W-1:0]     slots;
   logic                                 accept_c;

   assign accept_c = in_valid && in_ready;

   strassen_slot_bank #(
      .DATA_W (DATA_W)
   ) u_slot_bank (
      .clk   (clk),
      .clr_n (rst_n),
      .we    (accept_c),
      .idx   (idx),
      .wdata (in_data),
      .slots (slots)
   );

   assign mm_a11 = slots[SLOT_A11];
   assign mm_a12 = slots[SLOT_A12];
   assign mm_a21 = slots[SLOT_A21];
   assign mm_a22 = slots[SLOT_A22];
   assign mm_b11 = slots[SLOT_B11];
   assign mm_b12 = slots[SLOT_B12];
   assign mm_b21 = slots[SLOT_B21];
   assign mm_b22 = slots[SLOT_B22];

   // in_ready/out_valid are registered from the next state, never from in_valid/out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_c11   <= '0;
         out_c12   <= '0;
         out_c21   <= '0;
         out_c22   <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept_c) begin
                  idx   <= SLOT_IDX_W'(1);
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (accept_c) begin
                  if (idx == SLOT_B22) begin
                     idx      <= '0;
                     cnt      <= CNT_W'(MULT_LAT);
                     in_ready <= 1'b0;
                     state    <= WAIT;
                  end else begin
                     idx <= SLOT_IDX_W'(idx + SLOT_IDX_W'(1));
                  end
               end
            end
            WAIT: begin
               cnt <= CNT_W'(cnt - CNT_W'(1));
               if (cnt == CNT_W'(1)) begin
                  out_c11   <= mm_c11;
                  out_c12   <= mm_c12;
                  out_c21   <= mm_c21;
                  out_c22   <= mm_c22;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef STRASSEN_LOADER_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tile_count <= '0;
      end else if (out_valid && out_ready && (tile_count != 16'hFFFF)) begin
         tile_count <= tile_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_strassen_tile_loader.sv
// Scoreboard bench for strassen_tile_loader with a pipelined matmult1 model attached.
module tb_strassen_tile_loader;

   localparam int unsigned W = 32;
   localparam int unsigned L = 3;

   typedef struct {
      logic [W-1:0] c11;
      logic [W-1:0] c12;
      logic [W-1:0] c21;
      logic [W-1:0] c22;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [W-1:0] mm_a11, mm_a12, mm_a21, mm_a22;
   logic [W-1:0] mm_b11, mm_b12, mm_b21, mm_b22;
   logic [W-1:0] mm_c11, mm_c12, mm_c21, mm_c22;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_c11, out_c12, out_c21, out_c22;
`ifdef STRASSEN_LOADER_PERF_EN
   logic [15:0]  tile_count;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   acc8   = 0;
   logic prev_ov = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   strassen_tile_loader #(
      .DATA_W   (W),
      .MULT_LAT (L)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mm_a11    (mm_a11),
      .mm_a12    (mm_a12),
      .mm_a21    (mm_a21),
      .mm_a22    (mm_a22),
      .mm_b11    (mm_b11),
      .mm_b12    (mm_b12),
      .mm_b21    (mm_b21),
      .mm_b22    (mm_b22),
      .mm_c11    (mm_c11),
      .mm_c12    (mm_c12),
      .mm_c21    (mm_c21),
      .mm_c22    (mm_c22),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c11   (out_c11),
      .out_c12   (out_c12),
      .out_c21   (out_c21),
      .out_c22   (out_c22)
`ifdef STRASSEN_LOADER_PERF_EN
      ,
      .tile_count(tile_count)
`endif
   );

   // matmult1 model: results valid L edges after the operands settle
   logic [W-1:0]   p11, p12, p21, p22;
   logic [4*W-1:0] pipe [L-1];
   assign p11 = mm_a11 * mm_b11 + mm_a12 * mm_b21;
   assign p12 = mm_a11 * mm_b12 + mm_a12 * mm_b22;
   assign p21 = mm_a21 * mm_b11 + mm_a22 * mm_b21;
   assign p22 = mm_a21 * mm_b12 + mm_a22 * mm_b22;
   always @(posedge clk) begin
      pipe[0] <= {p11, p12, p21, p22};
      for (int i = 1; i < int'(L) - 1; i++) pipe[i] <= pipe[i-1];
   end
   assign {mm_c11, mm_c12, mm_c21, mm_c22} = pipe[L-2];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, $signed(act), $signed(exp));
      end
   endtask

   // Monitor: latency on every rise, scoreboard pop on every handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !prev_ov) chk("latency", W'(cyc - acc8), W'(L));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out got c11=%0d expected no tile", $signed(out_c11));
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("c11", out_c11, e.c11);
               chk("c12", out_c12, e.c12);
               chk("c21", out_c21, e.c21);
               chk("c22", out_c22, e.c22);
            end
         end
      end
      prev_ov = out_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input bit gap);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", W'(in_ready), W'(1));
      step();
      acc8     = cyc;
      in_valid = 1'b0;
      if (gap) step();
   endtask

   task automatic send_tile(input int t[8], input bit gap, input exp_t e);
      q.push_back(e);
      for (int i = 0; i < 8; i++) send(W'(t[i]), gap);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      chk("drain", W'(q.size()), W'(0));
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step();
      chk("rst_in_ready", W'(in_ready), W'(0));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_mm_a11", mm_a11, W'(0));
      chk("rst_mm_a22", mm_a22, W'(0));
      chk("rst_out_c11", out_c11, W'(0));
      chk("rst_out_c22", out_c22, W'(0));
      rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", W'(in_ready), W'(1));
   endtask

   initial begin
      int seq[8];
      int neg[8];
      int t99[8];
      exp_t e_seq, e_neg, e_99;
      seq = '{0, 1, 2, 3, 4, 5, 6, 7};
      neg = '{-1, 2, 3, -4, 5, -6, -7, 8};
      t99 = '{99, 1, 2, 3, 4, 5, 6, 7};
      e_seq = '{c11: W'(6),   c12: W'(7),   c21: W'(26), c22: W'(31)};
      e_neg = '{c11: -W'(19), c12: W'(22),  c21: W'(43), c22: -W'(50)};
      e_99  = '{c11: W'(402), c12: W'(502), c21: W'(26), c22: W'(31)};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      step();
      step();
      pulse_reset();

      // basic tile
      out_ready = 1'b1;
      send_tile(seq, 1'b0, e_seq);
      wait_idle();

      // gapped input, then backpressure in OUT
      out_ready = 1'b0;
      send_tile(seq, 1'b1, e_seq);
      for (int n = 0; n < 50 && !out_valid; n++) step();
      chk("stall_ov", W'(out_valid), W'(1));
      for (int i = 0; i < 5; i++) begin
         chk("stall_c11", out_c11, e_seq.c11);
         chk("stall_c22", out_c22, e_seq.c22);
         chk("stall_in_ready", W'(in_ready), W'(0));
         step();
      end
      out_ready = 1'b1;
      step();
      chk("hs_in_ready", W'(in_ready), W'(1));
      chk("hs_out_valid", W'(out_valid), W'(0));

      // negative operands
      send_tile(neg, 1'b0, e_neg);
      wait_idle();

      // input held during WAIT/OUT must not be consumed
      send_tile(seq, 1'b0, e_seq);
      in_valid  = 1'b1;
      in_data   = W'(99);
      out_ready = 1'b0;
      for (int n = 0; n < 50 && !out_valid; n++) begin
         chk("hold_in_ready", W'(in_ready), W'(0));
         chk("hold_mm_a11", mm_a11, W'(0));
         step();
      end
      for (int i = 0; i < 3; i++) begin
         chk("out_mm_a11", mm_a11, W'(0));
         chk("out_mm_b22", mm_b22, W'(7));
         step();
      end
      out_ready = 1'b1;
      q.push_back(e_99);
      for (int i = 0; i < 8; i++) begin
         send(W'(t99[i]), 1'b0);
         if (i == 0) chk("a11_99", mm_a11, W'(99));
      end
      wait_idle();

      // reset after five elements discards the partial tile
      for (int i = 0; i < 5; i++) send(W'(neg[i]), 1'b0);
      pulse_reset();
      send_tile(seq, 1'b0, e_seq);
      wait_idle();

`ifdef STRASSEN_LOADER_PERF_EN
      pulse_reset();
      chk("tc_reset0", W'(tile_count), W'(0));
      for (int t = 1; t <= 3; t++) begin
         send_tile(seq, 1'b0, e_seq);
         wait_idle();
         chk("tile_count", W'(tile_count), W'(t));
      end
      pulse_reset();
      chk("tc_reset", W'(tile_count), W'(0));
`endif

      for (int i = 0; i < 10; i++) step();
      chk("final_queue", W'(q.size()), W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1);
   end

endmodule
